unidade_busca: RTL and testbench



---
 rtl/unidade_busca.sv | 97 +++++++++
 tb/tb_unidade_busca.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch; PC register addresses memoria_instrucao, {pc, word} buffered in a small FIFO.
// Latency: a word addressed this cycle is presented at the FIFO head after the next rising edge; one bubble after a redirect.
// Backpressure: saida_pronta=0 fills the FIFO, then PC/endereco hold; a redirect flushes regardless of saida_pronta.
module unidade_busca #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter int          PROFUNDIDADE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  endereco,
  input  logic [31:0] dado,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [31:0] instrucao,
  output logic [31:0] pc_instrucao
);

  localparam int            PW     = $clog2(PROFUNDIDADE);
  localparam int            CW     = PW + 1;
  localparam logic [CW-1:0] CHEIO  = CW'(PROFUNDIDADE);
  localparam logic [31:0]   PC_INI = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0]   NOP    = 32'h00000013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_pc_q    [PROFUNDIDADE];
  logic [31:0]   fifo_instr_q [PROFUNDIDADE];
  logic          pop, push;

  // Head is taken straight from registers; saida_pronta never reaches saida_valida.
  assign endereco     = pc_q[9:2];
  assign saida_valida = (count_q != '0);
  assign instrucao    = saida_valida ? fifo_instr_q[rd_ptr_q] : NOP;
  assign pc_instrucao = saida_valida ? fifo_pc_q[rd_ptr_q] : 32'h00000000;

  // Next-state: redirect wins and empties the FIFO; otherwise push when there is room (a pop frees room).
  always_comb begin
    pop      = saida_valida && saida_pronta;
    push     = !desvio_valido && ((count_q != CHEIO) || pop);
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (desvio_valido) begin
      pc_d     = {desvio_alvo[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // PC, occupancy and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_INI;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; dado is captured only on push edges so an undriven bus never lands in an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        fifo_pc_q[i]    <= 32'h00000000;
        fifo_instr_q[i] <= NOP;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= dado;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed vectors for the fetch stage with hand-computed expectations.
// Two instances: default RESET_PC for most scenarios, RESET_PC=0x3F8 for the address wrap case.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_unidade_busca;

  logic        clk;
  logic        rst_n, rst2_n;
  logic [7:0]  endereco, endereco2;
  logic [31:0] dado, dado2;
  logic        desvio_valido;
  logic [31:0] desvio_alvo;
  logic        saida_valida, saida_valida2;
  logic        saida_pronta;
  logic [31:0] instrucao, instrucao2;
  logic [31:0] pc_instrucao, pc_instrucao2;

  logic [31:0] mem [256];

  int n_chk;
  int n_ok;

  assign dado  = mem[endereco];
  assign dado2 = mem[endereco2];

  unidade_busca #(.RESET_PC(32'h00000000), .PROFUNDIDADE(2)) dut (
    .clk(clk), .rst_n(rst_n), .endereco(endereco), .dado(dado),
    .desvio_valido(desvio_valido), .desvio_alvo(desvio_alvo),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .instrucao(instrucao), .pc_instrucao(pc_instrucao)
  );

  unidade_busca #(.RESET_PC(32'h000003F8), .PROFUNDIDADE(2)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .endereco(endereco2), .dado(dado2),
    .desvio_valido(1'b0), .desvio_alvo(32'h00000000),
    .saida_valida(saida_valida2), .saida_pronta(1'b1),
    .instrucao(instrucao2), .pc_instrucao(pc_instrucao2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      n_ok++;
    end
  endtask

  task automatic head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
    chk({tag, ".valida"}, {31'd0, saida_valida}, 32'd1);
    chk({tag, ".pc"}, pc_instrucao, exp_pc);
    chk({tag, ".instr"}, instrucao, exp_ins);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".valida"}, {31'd0, saida_valida}, 32'd0);
    chk({tag, ".instr"}, instrucao, 32'h00000013);
    chk({tag, ".pc"}, pc_instrucao, 32'h00000000);
  endtask

  // Assert reset for one cycle, release on a falling edge; the next rising edge is the first push.
  task automatic restart(input logic pronta);
    @(negedge clk);
    rst_n         = 1'b0;
    desvio_valido = 1'b0;
    desvio_alvo   = 32'h00000000;
    saida_pronta  = pronta;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_ok  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0000000 | i;
    mem[0] = 32'h001101B3;
    mem[1] = 32'h0000000C;
    mem[2] = 32'h00005FD3;

    rst_n         = 1'b0;
    rst2_n        = 1'b0;
    desvio_valido = 1'b0;
    desvio_alvo   = 32'h00000000;
    saida_pronta  = 1'b1;

    // Reset state and free-run
    @(negedge clk);
    idle("rst");
    chk("rst.end", {24'd0, endereco}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("s1.end0", {24'd0, endereco}, 32'd0);
    @(negedge clk);
    head("s1.h0", 32'h0, 32'h001101B3);
    chk("s1.end1", {24'd0, endereco}, 32'd1);
    @(negedge clk);
    head("s1.h1", 32'h4, 32'h0000000C);
    chk("s1.end2", {24'd0, endereco}, 32'd2);
    @(negedge clk);
    head("s1.h2", 32'h8, 32'h00005FD3);
    chk("s1.end3", {24'd0, endereco}, 32'd3);

    // Back-pressure: FIFO fills to two, PC holds, then drains in order
    restart(1'b0);
    repeat (5) @(negedge clk);
    head("s2.stall", 32'h0, 32'h001101B3);
    chk("s2.end_hold", {24'd0, endereco}, 32'd2);
    saida_pronta = 1'b1;
    @(negedge clk);
    head("s2.d1", 32'h4, 32'h0000000C);
    @(negedge clk);
    head("s2.d2", 32'h8, 32'h00005FD3);
    @(negedge clk);
    head("s2.d3", 32'hC, 32'hA0000003);

    // Redirect while head is pc=4
    restart(1'b1);
    @(negedge clk);
    head("s3.h0", 32'h0, 32'h001101B3);
    @(negedge clk);
    head("s3.h1", 32'h4, 32'h0000000C);
    desvio_valido = 1'b1;
    desvio_alvo   = 32'h00000022;
    @(negedge clk);
    desvio_valido = 1'b0;
    idle("s3.bolha");
    chk("s3.end", {24'd0, endereco}, 32'h08);
    @(negedge clk);
    head("s3.alvo", 32'h20, 32'hA0000008);
    @(negedge clk);
    head("s3.seg", 32'h24, 32'hA0000009);

    // Redirect while full and stalled
    restart(1'b0);
    repeat (3) @(negedge clk);
    head("s4.cheio", 32'h0, 32'h001101B3);
    desvio_valido = 1'b1;
    desvio_alvo   = 32'h00000040;
    @(negedge clk);
    desvio_valido = 1'b0;
    saida_pronta  = 1'b1;
    idle("s4.bolha");
    chk("s4.end", {24'd0, endereco}, 32'h10);
    @(negedge clk);
    head("s4.alvo", 32'h40, 32'hA0000010);
    @(negedge clk);
    head("s4.seg", 32'h44, 32'hA0000011);

    // Asynchronous reset between edges while full
    restart(1'b0);
    repeat (3) @(negedge clk);
    chk("s6.end_cheio", {24'd0, endereco}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    idle("s6.arst");
    chk("s6.end", {24'd0, endereco}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    saida_pronta = 1'b1;
    @(negedge clk);
    head("s6.reinicio", 32'h0, 32'h001101B3);

    // Address wrap from RESET_PC=0x3F8
    chk("s5.end_rst", {24'd0, endereco2}, 32'hFE);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("s5.v0", {31'd0, saida_valida2}, 32'd1);
    chk("s5.pc0", pc_instrucao2, 32'h3F8);
    chk("s5.ins0", instrucao2, 32'hA00000FE);
    chk("s5.end0", {24'd0, endereco2}, 32'hFF);
    @(negedge clk);
    chk("s5.pc1", pc_instrucao2, 32'h3FC);
    chk("s5.ins1", instrucao2, 32'hA00000FF);
    chk("s5.end1", {24'd0, endereco2}, 32'h00);
    @(negedge clk);
    chk("s5.pc2", pc_instrucao2, 32'h400);
    chk("s5.ins2", instrucao2, 32'h001101B3);
    chk("s5.end2", {24'd0, endereco2}, 32'h01);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
